// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl
// Sequences the branch predictor between fetch and execute.
//   - Each fetched conditional branch asks the predictor for a direction.
//     That prediction is recorded in an in-order in-flight queue.
//   - Each resolved branch is compared with the oldest recorded prediction.
//     The predictor is then trained with the actual outcome.
//   - A mispredict clears the queue and raises a timed flush/redirect.
//     Fetch is stalled while the flush is active.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   branch_fetch, pred_in      fetched branch / predictor output
//   predict, pred_taken        prediction request / prediction to fetch
//   branch_resolve, branch_taken   oldest branch resolved / its outcome
//   train_valid, train_outcome     one-cycle predictor training pulse
//   fetch_stall                fetch must hold the current branch
//   flush, redirect_taken      pipeline flush and refetch direction
//   inflight_count             queue occupancy
//   resolve_err                sticky: resolve seen with an empty queue
//   mispredict_count           saturating mispredict counter
//
// Build option: define BRP_STATS_EN to build the mispredict counter.
// Without it, mispredict_count is tied to zero.

module branch_resolve_ctrl #(
   parameter int DEPTH        = 4,
   parameter int PTR_W        = 2,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             branch_fetch,
   input  logic             pred_in,
   output logic             predict,
   output logic             pred_taken,
   input  logic             branch_resolve,
   input  logic             branch_taken,
   output logic             train_valid,
   output logic             train_outcome,
   output logic             fetch_stall,
   output logic             flush,
   output logic             redirect_taken,
   output logic [PTR_W:0]   inflight_count,
   output logic             resolve_err,
   output logic [CNT_W-1:0] mispredict_count
);

   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   head_q, tail_q;
   logic [PTR_W:0]     count_q, count_d;
   logic [DEPTH-1:0]   pred_q;
   logic [FC_W-1:0]    flush_cnt_q;
   logic               train_valid_q, train_outcome_q, redirect_q, resolve_err_q;

   logic in_flush, not_empty, full, resolve_ok, mispredict_now, push;

   // Per-cycle decode of the queue and the resolve path.
   // Resolves are only honoured with something in flight and outside a flush.
   // A full queue stays open while resolving, so a simultaneous pop can free a slot.
   always_comb begin
      in_flush       = (state_q == FLUSH);
      not_empty      = (count_q != '0);
      full           = (count_q == (PTR_W+1)'(DEPTH));
      resolve_ok     = branch_resolve && not_empty && !in_flush;
      mispredict_now = resolve_ok && (branch_taken != pred_q[head_q]);
      fetch_stall    = (full && !branch_resolve) || in_flush || mispredict_now;
      predict        = branch_fetch && !fetch_stall;
      pred_taken     = predict && pred_in;
      push           = predict;
   end

   // Next occupancy.
   // A mispredict wipes the queue, which also drops any same-cycle push.
   always_comb begin
      count_d = count_q;
      if (mispredict_now) begin
         count_d = '0;
      end else begin
         case ({push, resolve_ok})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Next-state logic.
   // FLUSH is left once its down-counter has reached zero.
   // Outside FLUSH, the state simply reflects whether anything is in flight.
   always_comb begin
      state_d = state_q;
      if (mispredict_now) begin
         state_d = FLUSH;
      end else if (in_flush) begin
         if (flush_cnt_q == '0) state_d = IDLE;
      end else begin
         state_d = (count_d != '0) ? TRACK : IDLE;
      end
   end

   // State register, queue storage and the registered output pulses.
   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         head_q          <= '0;
         tail_q          <= '0;
         count_q         <= '0;
         pred_q          <= '0;
         flush_cnt_q     <= '0;
         train_valid_q   <= 1'b0;
         train_outcome_q <= 1'b0;
         redirect_q      <= 1'b0;
         resolve_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         train_valid_q <= resolve_ok;
         if (resolve_ok) train_outcome_q <= branch_taken;
         if (mispredict_now) begin
            head_q      <= '0;
            tail_q      <= '0;
            redirect_q  <= branch_taken;
            flush_cnt_q <= FC_W'(FLUSH_CYCLES - 1);
         end else begin
            if (push) begin
               pred_q[tail_q] <= pred_in;
               tail_q         <= tail_q + PTR_W'(1);
            end
            if (resolve_ok) head_q <= head_q + PTR_W'(1);
            if (in_flush && flush_cnt_q != '0) flush_cnt_q <= flush_cnt_q - FC_W'(1);
         end
         if (branch_resolve && !not_empty && !in_flush) resolve_err_q <= 1'b1;
      end
   end

   assign train_valid    = train_valid_q;
   assign train_outcome  = train_outcome_q;
   assign flush          = in_flush;
   assign redirect_taken = redirect_q && in_flush;
   assign inflight_count = count_q;
   assign resolve_err    = resolve_err_q;

`ifdef BRP_STATS_EN
   logic [CNT_W-1:0] mispredict_cnt_q;

   // Saturating count of mispredict edges since reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         mispredict_cnt_q <= '0;
      end else if (mispredict_now && mispredict_cnt_q != '1) begin
         mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
      end
   end

   assign mispredict_count = mispredict_cnt_q;
`else
   assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed self-checking bench for branch_resolve_ctrl (DEPTH=4, FLUSH_CYCLES=2).
// Inputs change 1 time unit after the rising edge.
// Outputs are sampled in the same window, away from the edge.

module tb_branch_resolve_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        branch_fetch = 1'b0;
   logic        pred_in = 1'b0;
   logic        predict, pred_taken;
   logic        branch_resolve = 1'b0;
   logic        branch_taken = 1'b0;
   logic        train_valid, train_outcome, fetch_stall, flush, redirect_taken;
   logic [2:0]  inflight_count;
   logic        resolve_err;
   logic [15:0] mispredict_count;

   int checks = 0;
   int failures = 0;

`ifdef BRP_STATS_EN
   localparam logic [15:0] STATS_ONE = 16'd1;
   localparam logic [15:0] STATS_TWO = 16'd2;
`else
   localparam logic [15:0] STATS_ONE = 16'd0;
   localparam logic [15:0] STATS_TWO = 16'd0;
`endif

   branch_resolve_ctrl dut (
      .clk(clk), .reset(reset),
      .branch_fetch(branch_fetch), .pred_in(pred_in),
      .predict(predict), .pred_taken(pred_taken),
      .branch_resolve(branch_resolve), .branch_taken(branch_taken),
      .train_valid(train_valid), .train_outcome(train_outcome),
      .fetch_stall(fetch_stall), .flush(flush), .redirect_taken(redirect_taken),
      .inflight_count(inflight_count), .resolve_err(resolve_err),
      .mispredict_count(mispredict_count)
   );

   // 10-unit clock period.
   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one clock edge, then step clear of it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      checks++; if (inflight_count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d required 0", inflight_count); end
      checks++; if (flush !== 1'b0) begin failures++; $display("[TB] FAIL reset_flush: got %0b required 0", flush); end
      checks++; if (train_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_train: got %0b required 0", train_valid); end
      checks++; if (resolve_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %0b required 0", resolve_err); end
      checks++; if (redirect_taken !== 1'b0) begin failures++; $display("[TB] FAIL reset_redirect: got %0b required 0", redirect_taken); end
      checks++; if (mispredict_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_mcount: got %0d required 0", mispredict_count); end
      checks++; if (fetch_stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %0b required 0", fetch_stall); end
   endtask

   // Three fetches with predictions 1,0,1 on consecutive cycles.
   task automatic test_fetch();
      logic [2:0] preds;
      preds = 3'b101;
      for (int i = 0; i < 3; i++) begin
         branch_fetch = 1'b1;
         pred_in      = preds[i];
         #1;
         checks++; if (predict !== 1'b1) begin failures++; $display("[TB] FAIL fetch_predict%0d: got %0b required 1", i, predict); end
         checks++; if (pred_taken !== preds[i]) begin failures++; $display("[TB] FAIL fetch_pred_taken%0d: got %0b required %0b", i, pred_taken, preds[i]); end
         tick();
      end
      branch_fetch = 1'b0;
      #1;
      checks++; if (inflight_count !== 3'd3) begin failures++; $display("[TB] FAIL fetch_count: got %0d required 3", inflight_count); end
      checks++; if (fetch_stall !== 1'b0) begin failures++; $display("[TB] FAIL fetch_stall: got %0b required 0", fetch_stall); end
   endtask

   // Fill to DEPTH, stall a fifth fetch, then free a slot with a matching resolve.
   // Queue at entry holds 1,0,1. After the fourth push it holds 1,0,1,0.
   task automatic test_full();
      logic [3:0] drain;
      branch_fetch = 1'b1;
      pred_in      = 1'b0;
      tick();
      pred_in = 1'b1;
      #1;
      checks++; if (fetch_stall !== 1'b1) begin failures++; $display("[TB] FAIL full_stall: got %0b required 1", fetch_stall); end
      checks++; if (predict !== 1'b0) begin failures++; $display("[TB] FAIL full_predict: got %0b required 0", predict); end
      tick();
      checks++; if (inflight_count !== 3'd4) begin failures++; $display("[TB] FAIL full_count: got %0d required 4", inflight_count); end
      // The head prediction is 1, so resolving taken matches it.
      branch_resolve = 1'b1;
      branch_taken   = 1'b1;
      #1;
      checks++; if (predict !== 1'b1) begin failures++; $display("[TB] FAIL full_pushpop_predict: got %0b required 1", predict); end
      tick();
      branch_resolve = 1'b0;
      branch_fetch   = 1'b0;
      checks++; if (inflight_count !== 3'd4) begin failures++; $display("[TB] FAIL full_pushpop_count: got %0d required 4", inflight_count); end
      checks++; if (train_valid !== 1'b1) begin failures++; $display("[TB] FAIL full_train_valid: got %0b required 1", train_valid); end
      checks++; if (train_outcome !== 1'b1) begin failures++; $display("[TB] FAIL full_train_outcome: got %0b required 1", train_outcome); end
      tick();
      checks++; if (train_valid !== 1'b0) begin failures++; $display("[TB] FAIL full_train_once: got %0b required 0", train_valid); end
      // The queue now holds 0,1,0,1 across the wrapped pointers.
      // Drain it with matching outcomes.
      drain = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         branch_resolve = 1'b1;
         branch_taken   = drain[i];
         tick();
         checks++; if (flush !== 1'b0) begin failures++; $display("[TB] FAIL drain_flush%0d: got %0b required 0", i, flush); end
      end
      branch_resolve = 1'b0;
      checks++; if (inflight_count !== 3'd0) begin failures++; $display("[TB] FAIL drain_count: got %0d required 0", inflight_count); end
      checks++; if (train_outcome !== 1'b1) begin failures++; $display("[TB] FAIL drain_outcome: got %0b required 1", train_outcome); end
   endtask

   // Queue holds 1,1; a correct resolve trains without a flush.
   task automatic test_correct_resolve();
      branch_fetch = 1'b1;
      pred_in      = 1'b1;
      tick();
      tick();
      branch_fetch   = 1'b0;
      branch_resolve = 1'b1;
      branch_taken   = 1'b1;
      tick();
      branch_resolve = 1'b0;
      checks++; if (flush !== 1'b0) begin failures++; $display("[TB] FAIL correct_flush: got %0b required 0", flush); end
      checks++; if (train_valid !== 1'b1) begin failures++; $display("[TB] FAIL correct_train_valid: got %0b required 1", train_valid); end
      checks++; if (train_outcome !== 1'b1) begin failures++; $display("[TB] FAIL correct_train_outcome: got %0b required 1", train_outcome); end
      checks++; if (inflight_count !== 3'd1) begin failures++; $display("[TB] FAIL correct_count: got %0d required 1", inflight_count); end
      branch_resolve = 1'b1;
      tick();
      branch_resolve = 1'b0;
      checks++; if (inflight_count !== 3'd0) begin failures++; $display("[TB] FAIL correct_drain: got %0d required 0", inflight_count); end
   endtask

   // Mispredict with a same-cycle fetch, a two-cycle flush, then a taken redirect.
   task automatic test_mispredict();
      branch_fetch = 1'b1;
      pred_in      = 1'b1;
      tick();
      branch_resolve = 1'b1;
      branch_taken   = 1'b0;
      #1;
      checks++; if (fetch_stall !== 1'b1) begin failures++; $display("[TB] FAIL misp_stall: got %0b required 1", fetch_stall); end
      checks++; if (predict !== 1'b0) begin failures++; $display("[TB] FAIL misp_predict: got %0b required 0", predict); end
      tick();
      branch_resolve = 1'b0;
      checks++; if (flush !== 1'b1) begin failures++; $display("[TB] FAIL misp_flush1: got %0b required 1", flush); end
      checks++; if (redirect_taken !== 1'b0) begin failures++; $display("[TB] FAIL misp_redirect1: got %0b required 0", redirect_taken); end
      checks++; if (inflight_count !== 3'd0) begin failures++; $display("[TB] FAIL misp_count: got %0d required 0", inflight_count); end
      checks++; if (train_valid !== 1'b1) begin failures++; $display("[TB] FAIL misp_train_valid: got %0b required 1", train_valid); end
      checks++; if (train_outcome !== 1'b0) begin failures++; $display("[TB] FAIL misp_train_outcome: got %0b required 0", train_outcome); end
      checks++; if (predict !== 1'b0) begin failures++; $display("[TB] FAIL misp_predict_flush1: got %0b required 0", predict); end
      tick();
      checks++; if (flush !== 1'b1) begin failures++; $display("[TB] FAIL misp_flush2: got %0b required 1", flush); end
      checks++; if (inflight_count !== 3'd0) begin failures++; $display("[TB] FAIL misp_count2: got %0d required 0", inflight_count); end
      checks++; if (train_valid !== 1'b0) begin failures++; $display("[TB] FAIL misp_train_in_flush: got %0b required 0", train_valid); end
      tick();
      checks++; if (flush !== 1'b0) begin failures++; $display("[TB] FAIL misp_flush_drop: got %0b required 0", flush); end
      checks++; if (predict !== 1'b1) begin failures++; $display("[TB] FAIL misp_predict_resume: got %0b required 1", predict); end
      checks++; if (mispredict_count !== STATS_ONE) begin failures++; $display("[TB] FAIL misp_mcount1: got %0d required %0d", mispredict_count, STATS_ONE); end
      tick();
      branch_fetch = 1'b0;
      checks++; if (inflight_count !== 3'd1) begin failures++; $display("[TB] FAIL misp_refetch_count: got %0d required 1", inflight_count); end
      // Retire that entry correctly.
      branch_resolve = 1'b1;
      branch_taken   = 1'b1;
      tick();
      branch_resolve = 1'b0;
      // Predict not-taken, then resolve taken, which must redirect taken.
      branch_fetch = 1'b1;
      pred_in      = 1'b0;
      tick();
      branch_fetch   = 1'b0;
      branch_resolve = 1'b1;
      branch_taken   = 1'b1;
      tick();
      branch_resolve = 1'b0;
      checks++; if (redirect_taken !== 1'b1) begin failures++; $display("[TB] FAIL misp_redirect_taken1: got %0b required 1", redirect_taken); end
      tick();
      checks++; if (redirect_taken !== 1'b1) begin failures++; $display("[TB] FAIL misp_redirect_taken2: got %0b required 1", redirect_taken); end
      tick();
      checks++; if (flush !== 1'b0) begin failures++; $display("[TB] FAIL misp_flush_drop2: got %0b required 0", flush); end
      checks++; if (mispredict_count !== STATS_TWO) begin failures++; $display("[TB] FAIL misp_mcount2: got %0d required %0d", mispredict_count, STATS_TWO); end
   endtask

   // A resolve on an empty queue sets the sticky error and does not train.
   task automatic test_resolve_empty();
      branch_resolve = 1'b1;
      branch_taken   = 1'b1;
      tick();
      branch_resolve = 1'b0;
      checks++; if (train_valid !== 1'b0) begin failures++; $display("[TB] FAIL empty_train: got %0b required 0", train_valid); end
      checks++; if (resolve_err !== 1'b1) begin failures++; $display("[TB] FAIL empty_err: got %0b required 1", resolve_err); end
      checks++; if (inflight_count !== 3'd0) begin failures++; $display("[TB] FAIL empty_count: got %0d required 0", inflight_count); end
      branch_fetch = 1'b1;
      pred_in      = 1'b1;
      tick();
      branch_fetch   = 1'b0;
      branch_resolve = 1'b1;
      tick();
      branch_resolve = 1'b0;
      checks++; if (train_valid !== 1'b1) begin failures++; $display("[TB] FAIL empty_later_train: got %0b required 1", train_valid); end
      checks++; if (resolve_err !== 1'b1) begin failures++; $display("[TB] FAIL empty_err_sticky: got %0b required 1", resolve_err); end
   endtask

   // Reset during the first flush cycle, then reset with three entries in flight.
   task automatic test_reset_mid();
      branch_fetch = 1'b1;
      pred_in      = 1'b1;
      tick();
      branch_fetch   = 1'b0;
      branch_resolve = 1'b1;
      branch_taken   = 1'b0;
      tick();
      branch_resolve = 1'b0;
      checks++; if (flush !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_pre_flush: got %0b required 1", flush); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (flush !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_flush: got %0b required 0", flush); end
      checks++; if (inflight_count !== 3'd0) begin failures++; $display("[TB] FAIL rst_mid_count: got %0d required 0", inflight_count); end
      checks++; if (resolve_err !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_err: got %0b required 0", resolve_err); end
      checks++; if (mispredict_count !== 16'd0) begin failures++; $display("[TB] FAIL rst_mid_mcount: got %0d required 0", mispredict_count); end
      checks++; if (train_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_train: got %0b required 0", train_valid); end
      branch_fetch = 1'b1;
      tick();
      tick();
      tick();
      branch_fetch = 1'b0;
      checks++; if (inflight_count !== 3'd3) begin failures++; $display("[TB] FAIL rst_fill_count: got %0d required 3", inflight_count); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (inflight_count !== 3'd0) begin failures++; $display("[TB] FAIL rst_inflight_count: got %0d required 0", inflight_count); end
      checks++; if (flush !== 1'b0) begin failures++; $display("[TB] FAIL rst_inflight_flush: got %0b required 0", flush); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_full();
      test_correct_resolve();
      test_mispredict();
      test_resolve_empty();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Sequences the branch predictor for the fetch/execute pipeline.
- On each fetched conditional branch, requests a prediction and records it in an in-order in-flight queue.
- On each resolved branch, compares the actual outcome with the oldest recorded prediction, then trains the predictor with the actual outcome.
- On a mispredict, issues a timed flush/redirect and stalls fetch.

Parameters:
DEPTH, 4, in-flight branch queue entries (power of two, >= 2)
PTR_W, 2, log2(DEPTH)
FLUSH_CYCLES, 2, cycles flush is held after a mispredict (>= 1)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  synchronous active-high reset
branch_fetch  in  1  conditional branch in fetch this cycle
pred_in  in  1  predictor output (1 = taken), valid in the same cycle predict is high
predict  out  1  combinational prediction request to the predictor
pred_taken  out  1  prediction forwarded to fetch (equals pred_in when predict = 1, else 0)
branch_resolve  in  1  oldest in-flight branch resolved this cycle
branch_taken  in  1  actual outcome of the resolving branch
train_valid  out  1  registered one-cycle pulse: update predictor history
train_outcome  out  1  actual outcome to shift into predictor history
fetch_stall  out  1  fetch must hold the current branch
flush  out  1  pipeline flush, held FLUSH_CYCLES cycles
redirect_taken  out  1  direction to refetch; valid while flush = 1
inflight_count  out  PTR_W+1  entries in the queue
resolve_err  out  1  sticky: resolve seen with the queue empty
mispredict_count  out  CNT_W  mispredicts since reset (see Optional Feature)

Behaviour:
- Reset (synchronous): queue empty, pointers 0, state IDLE. train_valid, train_outcome, flush, redirect_taken and resolve_err are 0; counters are 0.
- States:
  - IDLE: count = 0.
  - TRACK: count > 0.
  - FLUSH: a down-counter loaded with FLUSH_CYCLES-1.
- mispredict_now (combinational): branch_resolve = 1, count > 0, state != FLUSH, and branch_taken differs from the head entry's prediction.
- fetch_stall (combinational): (count == DEPTH and not resolving this cycle) OR state == FLUSH OR mispredict_now.
- predict = branch_fetch AND NOT fetch_stall. When predict = 1, pred_in is pushed at the tail on the same posedge. Latency to the queue is 0 cycles.
- A resolve with count > 0 outside FLUSH pops the head.
  - Next cycle: train_valid = 1 and train_outcome = branch_taken, for exactly one cycle.
  - A push and a pop in the same cycle is legal, including when full; the count is unchanged.
- Mispredict:
  - On that edge: queue cleared (count 0, pointers 0), any same-cycle push dropped, state -> FLUSH.
  - From the next cycle: flush = 1 and redirect_taken = branch_taken for exactly FLUSH_CYCLES cycles. The train pulse is still issued.
- FLUSH:
  - branch_fetch and branch_resolve are ignored and no training occurs.
  - When the counter reaches 0 the state returns to IDLE, and flush drops on the following cycle edge.
- Resolve while empty (outside FLUSH): ignored, no train pulse, resolve_err is set and stays set until reset.
- Pointer wrap-around is modulo DEPTH. Count never exceeds DEPTH.
- Reset mid-flush or with entries in flight: everything returns to the reset state on the next edge.

Optional Feature:
Macro BRP_STATS_EN.
- Defined: mispredict_count increments by 1 on each mispredict edge and saturates at all-ones.
- Not defined: no counter logic is built and mispredict_count is tied to 0.
- The port exists in both builds.

Test Plan:
- Reset, then 3 fetches with pred_in = 1,0,1 on consecutive cycles -> predict high each cycle, inflight_count = 3, fetch_stall = 0.
- 4 fetches (DEPTH = 4) then a 5th fetch with no resolve -> fetch_stall = 1, predict = 0, inflight_count stays 4. On the same cycle add a resolve matching the head -> push accepted, count stays 4, train_valid pulses once.
- Queue holds preds 1,1. Resolve with branch_taken = 1 -> no flush; train_valid = 1, train_outcome = 1 next cycle; count = 1.
- Queue holds head pred 1, fetch asserted same cycle, resolve with branch_taken = 0 -> fetch dropped. flush = 1 and redirect_taken = 0 for exactly 2 cycles; count = 0; fetches ignored during flush; predict resumes after flush drops; mispredict_count = 1 with BRP_STATS_EN.
- Resolve on an empty queue -> no train pulse, resolve_err = 1 and stays 1 through further traffic until reset.
- Assert reset during the first flush cycle with 0 entries and while 3 entries are in flight -> next cycle flush = 0, inflight_count = 0, resolve_err = 0, mispredict_count = 0.
